pixel_dispatch: RTL and testbench

- Upstream neighbour of the pixel alignment/sort stage. Dispatches linear pixel addresses 0..H_DISP*V_DISP-1 round-robin to LANES parallel shading lanes that have variable latency.
- Merges lane results into a single data/data_addr/data_valid stream, at most one pixel per cycle.
- Caps in-flight pixels so every emitted address lies within WINDOW of the oldest unreturned pixel. This guarantees the downstream N-entry reorder buffer never aliases. Integration ties WINDOW = N.

---
 rtl/pixel_dispatch.sv | 163 ++++++++++++++++
 tb/tb_pixel_dispatch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatch.sv
// Issues linear frame addresses round-robin to variable-latency shading lanes and merges
// their results into one stream, keeping every in-flight address within WINDOW of the oldest.
module pixel_dispatch #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int LANES  = 4,
    parameter int WINDOW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    output logic [LANES-1:0]    lane_req_valid,
    output logic [19:0]         lane_req_addr,
    input  logic [LANES-1:0]    lane_req_ready,
    input  logic [LANES-1:0]    lane_res_valid,
    input  logic [16*LANES-1:0] lane_res_data,
    input  logic [20*LANES-1:0] lane_res_addr,
    output logic [LANES-1:0]    lane_res_ready,
    output logic [15:0]         data,
    output logic [19:0]         data_addr,
    output logic                data_valid,
    output logic                busy,
    output logic                frame_done
);
    localparam int          PW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int          WW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [20:0] TOTAL = 21'(H_DISP * V_DISP);
    localparam logic [20:0] WIN   = 21'(WINDOW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [20:0]       issue_ptr_reg, issue_ptr_next;
    logic [20:0]       oldest_reg, oldest_next;
    logic [WINDOW-1:0] bitmap_reg, bitmap_next;
    logic [PW-1:0]     req_rr_reg, req_rr_next;
    logic [PW-1:0]     res_rr_reg, res_rr_next;
    logic [15:0]       data_reg, data_next;
    logic [19:0]       data_addr_reg, data_addr_next;
    logic              data_valid_reg, data_valid_next;

    logic [15:0]       lane_data [LANES];
    logic [19:0]       lane_tag  [LANES];
    logic [PW:0]       req_pick, res_pick;
    logic [PW-1:0]     req_lane, res_lane;
    logic [19:0]       res_tag;
    logic              active, issue_ok, issue_fire, res_fire, res_hit;
    logic [WINDOW-1:0] set_mask, clr_mask, cleared;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = lane_res_data[16*gi +: 16];
            assign lane_tag[gi]  = lane_res_addr[20*gi +: 20];
        end
    endgenerate

    // Returns {found, lane}: first set bit of req searching upward from start, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [LANES-1:0] req, input logic [PW-1:0] start);
        logic [PW:0] pick;
        int          idx;
        pick = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % LANES;
            if (req[PW'(idx)]) pick = {1'b1, PW'(idx)};
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] next_lane(input logic [PW-1:0] lane);
        return PW'((int'(lane) + 1) % LANES);
    endfunction

    always_comb begin
        req_pick   = rr_pick(lane_req_ready, req_rr_reg);
        res_pick   = rr_pick(lane_res_valid, res_rr_reg);
        req_lane   = req_pick[PW-1:0];
        res_lane   = res_pick[PW-1:0];
        active     = (state_reg == RUN) || (state_reg == DRAIN);
        issue_ok   = (state_reg == RUN) && (issue_ptr_reg < TOTAL) &&
                     ((issue_ptr_reg - oldest_reg) < WIN);
        issue_fire = !rst && issue_ok && req_pick[PW];
        res_fire   = !rst && res_pick[PW];
        res_tag    = lane_tag[res_lane];
        // Results outside a frame, or whose tag is not outstanding, are acked and dropped.
        res_hit    = res_fire && active && bitmap_reg[res_tag[WW-1:0]];

        lane_req_valid = '0;
        lane_res_ready = '0;
        set_mask       = '0;
        clr_mask       = '0;
        if (issue_fire) begin
            lane_req_valid[req_lane]        = 1'b1;
            set_mask[issue_ptr_reg[WW-1:0]] = 1'b1;
        end
        if (res_fire) lane_res_ready[res_lane] = 1'b1;
        if (res_hit) clr_mask[res_tag[WW-1:0]] = 1'b1;
        lane_req_addr = issue_fire ? issue_ptr_reg[19:0] : 20'd0;
        cleared       = bitmap_reg & ~clr_mask;

        state_next      = state_reg;
        issue_ptr_next  = issue_ptr_reg;
        oldest_next     = oldest_reg;
        bitmap_next     = cleared | set_mask;
        req_rr_next     = req_rr_reg;
        res_rr_next     = res_rr_reg;
        data_valid_next = res_hit;
        data_next       = res_hit ? lane_data[res_lane] : 16'd0;
        data_addr_next  = res_hit ? res_tag : 20'd0;

        if (issue_fire) begin
            issue_ptr_next = issue_ptr_reg + 21'd1;
            req_rr_next    = next_lane(req_lane);
        end
        if (res_fire) res_rr_next = next_lane(res_lane);
        if (active && (oldest_reg < issue_ptr_reg) && !cleared[oldest_reg[WW-1:0]])
            oldest_next = oldest_reg + 21'd1;

        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next     = RUN;
                    issue_ptr_next = '0;
                    oldest_next    = '0;
                    bitmap_next    = '0;
                end
            end
            RUN:     if (issue_fire && (issue_ptr_reg == TOTAL - 21'd1)) state_next = DRAIN;
            DRAIN:   if ((bitmap_reg == '0) && !res_fire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            issue_ptr_reg  <= '0;
            oldest_reg     <= '0;
            bitmap_reg     <= '0;
            req_rr_reg     <= '0;
            res_rr_reg     <= '0;
            data_reg       <= '0;
            data_addr_reg  <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            issue_ptr_reg  <= issue_ptr_next;
            oldest_reg     <= oldest_next;
            bitmap_reg     <= bitmap_next;
            req_rr_reg     <= req_rr_next;
            res_rr_reg     <= res_rr_next;
            data_reg       <= data_next;
            data_addr_reg  <= data_addr_next;
            data_valid_reg <= data_valid_next;
        end
    end

    assign data       = data_reg;
    assign data_addr  = data_addr_reg;
    assign data_valid = data_valid_reg;
    assign busy       = (state_reg == RUN) || (state_reg == DRAIN);
    assign frame_done = (state_reg == DONE);
endmodule

// File: tb/tb_pixel_dispatch.sv
// Scoreboard bench for pixel_dispatch: models the lanes, predicts each merged pixel at
// acceptance time and checks it when the DUT emits it.
module tb_pixel_dispatch;
    localparam int H = 4, V = 2, TOT = H * V, WIN = 4;

    logic        clk = 1'b0;
    logic        rst, frame_start, sel1;
    logic [1:0]  lane_ready, lane_valid;
    logic [31:0] lane_data;
    logic [39:0] lane_addr;

    logic [1:0]  d0_req_valid, d0_res_ready;
    logic [19:0] d0_req_addr, d0_data_addr;
    logic [15:0] d0_data;
    logic        d0_data_valid, d0_busy, d0_frame_done;
    logic [0:0]  d1_req_valid, d1_res_ready;
    logic [19:0] d1_req_addr, d1_data_addr;
    logic [15:0] d1_data;
    logic        d1_data_valid, d1_busy, d1_frame_done;

    logic [1:0]  req_valid, res_ready;
    logic [19:0] req_addr, out_addr;
    logic [15:0] out_data;
    logic        out_valid, busy, frame_done;

    always #5 clk = ~clk;

    pixel_dispatch #(.H_DISP(H), .V_DISP(V), .LANES(2), .WINDOW(WIN)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start & ~sel1),
        .lane_req_valid(d0_req_valid), .lane_req_addr(d0_req_addr), .lane_req_ready(lane_ready),
        .lane_res_valid(lane_valid), .lane_res_data(lane_data), .lane_res_addr(lane_addr),
        .lane_res_ready(d0_res_ready), .data(d0_data), .data_addr(d0_data_addr),
        .data_valid(d0_data_valid), .busy(d0_busy), .frame_done(d0_frame_done)
    );

    pixel_dispatch #(.H_DISP(H), .V_DISP(V), .LANES(1), .WINDOW(WIN)) dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start & sel1),
        .lane_req_valid(d1_req_valid), .lane_req_addr(d1_req_addr), .lane_req_ready(lane_ready[0:0]),
        .lane_res_valid(lane_valid[0:0]), .lane_res_data(lane_data[15:0]), .lane_res_addr(lane_addr[19:0]),
        .lane_res_ready(d1_res_ready), .data(d1_data), .data_addr(d1_data_addr),
        .data_valid(d1_data_valid), .busy(d1_busy), .frame_done(d1_frame_done)
    );

    always_comb begin
        if (sel1) begin
            req_valid  = {1'b0, d1_req_valid};
            res_ready  = {1'b0, d1_res_ready};
            req_addr   = d1_req_addr;
            out_addr   = d1_data_addr;
            out_data   = d1_data;
            out_valid  = d1_data_valid;
            busy       = d1_busy;
            frame_done = d1_frame_done;
        end else begin
            req_valid  = d0_req_valid;
            res_ready  = d0_res_ready;
            req_addr   = d0_req_addr;
            out_addr   = d0_data_addr;
            out_data   = d0_data;
            out_valid  = d0_data_valid;
            busy       = d0_busy;
            frame_done = d0_frame_done;
        end
    end

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int q_addr [2][16];
    int q_due  [2][16];
    int q_head [2];
    int q_cnt  [2];
    int lat    [2];
    int ready_mode, nl;
    bit m_active;
    bit outstanding [TOT];
    int seen [TOT];
    int m_issue, m_req_rr, m_res_rr;
    int n_out, n_done, next_out, max_span, last_issue_cyc, expect_dv, dv2_events, stale_acks;
    bit check_order, check_alt;
    int          exp_addr [$];
    logic [15:0] exp_data [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pix(input int a);
        return 16'(a * 1237 + 23130);
    endfunction

    function automatic int true_oldest();
        for (int a = 0; a < TOT; a++) if (outstanding[a]) return a;
        return m_issue;
    endfunction

    function automatic int n_outstanding();
        int n = 0;
        for (int a = 0; a < TOT; a++) n += int'(outstanding[a]);
        return n;
    endfunction

    function automatic int first_from(input logic [1:0] v, input int start, input int n);
        for (int k = 0; k < n; k++) if (v[(start + k) % n]) return (start + k) % n;
        return -1;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        int g, a, eg;
        logic [1:0] eg_vec;
        if (out_valid) begin
            $display("[cyc %0d] pixel addr=%0d data=%04h", cyc, out_addr, out_data);
            n_out++;
            if (out_addr < 20'(TOT)) seen[out_addr]++;
            if (expect_dv > 0) expect_dv--;
            if (exp_addr.size() == 0) check_val("unexpected_pixel", out_valid, 0);
            else begin
                check_val("pixel_addr", out_addr, exp_addr.pop_front());
                check_val("pixel_data", out_data, exp_data.pop_front());
            end
            if (check_order) begin
                check_val("pixel_order", out_addr, next_out);
                next_out++;
            end
        end else begin
            if (expect_dv > 0) begin
                check_val("back_to_back_valid", out_valid, 1);
                expect_dv = 0;
            end
            check_val("idle_output_zero", {out_data, out_addr}, 0);
        end
        if (frame_done === 1'b1) begin
            n_done++;
            m_active = 1'b0;
        end
        check_val("busy", busy, m_active);

        for (int l = 0; l < 2; l++) begin
            lane_ready[l] = (l < nl) && (ready_mode == 0 || cyc % 2 == 0);
            if (q_cnt[l] > 0 && q_due[l][q_head[l]] <= cyc) begin
                a = q_addr[l][q_head[l]];
                lane_valid[l]          = 1'b1;
                lane_data[16*l +: 16]  = pix(a);
                lane_addr[20*l +: 20]  = 20'(a);
            end else begin
                lane_valid[l]          = 1'b0;
                lane_data[16*l +: 16]  = '0;
                lane_addr[20*l +: 20]  = '0;
            end
        end
        #1;

        if (rst) begin
            check_val("reset_quiet", {req_valid, res_ready}, 0);
        end else begin
            check_val("req_onehot", $countones(req_valid) <= 1, 1);
            if (!m_active) check_val("req_when_idle", req_valid, 0);
            else if (req_valid == 2'b00) check_val("req_addr_idle", req_addr, 0);
            else begin
                g  = req_valid[1] ? 1 : 0;
                eg = first_from(lane_ready, m_req_rr, nl);
                check_val("req_to_ready_lane", lane_ready[g], 1);
                check_val("req_lane", g, eg);
                check_val("req_addr", req_addr, m_issue);
                check_val("issue_window", int'(req_addr) - true_oldest() < WIN, 1);
                if (check_alt) check_val("alternate_lane", g, int'(req_addr) % 2);
                if (ready_mode == 1) check_val("issue_gap", cyc - last_issue_cyc >= 2, 1);
                last_issue_cyc = cyc;
                q_addr[g][(q_head[g] + q_cnt[g]) % 16] = m_issue;
                q_due[g][(q_head[g] + q_cnt[g]) % 16]  = cyc + lat[g];
                q_cnt[g]++;
                if (m_issue < TOT) outstanding[m_issue] = 1'b1;
                m_issue++;
                m_req_rr = (g + 1) % nl;
                if (m_issue - true_oldest() > max_span) max_span = m_issue - true_oldest();
            end

            check_val("res_ready_subset", res_ready & ~lane_valid, 0);
            if (lane_valid != 2'b00) begin
                eg     = first_from(lane_valid, m_res_rr, nl);
                eg_vec = '0;
                eg_vec[eg] = 1'b1;
                check_val("res_grant", res_ready, eg_vec);
                if (res_ready != 2'b00) begin
                    g = res_ready[1] ? 1 : 0;
                    a = q_addr[g][q_head[g]];
                    q_head[g] = (q_head[g] + 1) % 16;
                    q_cnt[g]--;
                    m_res_rr = (g + 1) % nl;
                    if (m_active && a < TOT && outstanding[a]) begin
                        check_val("accept_window", a - true_oldest() < WIN, 1);
                        if (lane_valid == 2'b11 && nl == 2) begin
                            expect_dv = 2;
                            dv2_events++;
                        end
                        exp_addr.push_back(a);
                        exp_data.push_back(pix(a));
                        outstanding[a] = 1'b0;
                    end else begin
                        stale_acks++;
                    end
                end
            end
        end

        if (rst) begin
            m_active = 1'b0;
            for (int i = 0; i < TOT; i++) outstanding[i] = 1'b0;
            m_issue  = 0;
            m_req_rr = 0;
            m_res_rr = 0;
        end else if (frame_start && !m_active) begin
            m_active = 1'b1;
            m_issue  = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_frame(input string name, input int budget, input int inject_at);
        int d0, o0;
        d0 = n_done;
        o0 = n_out;
        for (int a = 0; a < TOT; a++) seen[a] = 0;
        next_out    = 0;
        frame_start = 1'b1;
        step();
        for (int i = 0; i < budget && n_done == d0; i++) begin
            frame_start = (i == inject_at);
            step();
        end
        frame_start = 1'b0;
        check_val({name, "_frame_done"}, n_done - d0, 1);
        repeat (3) step();
        check_val({name, "_frame_done_once"}, n_done - d0, 1);
        check_val({name, "_pixel_count"}, n_out - o0, TOT);
        for (int a = 0; a < TOT; a++) check_val({name, "_each_once"}, seen[a], 1);
        check_val({name, "_scoreboard_empty"}, exp_addr.size(), 0);
        check_val({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pending, stale0;
        rst = 1'b1; frame_start = 1'b0; sel1 = 1'b0;
        lane_ready = '0; lane_valid = '0; lane_data = '0; lane_addr = '0;
        for (int l = 0; l < 2; l++) begin q_head[l] = 0; q_cnt[l] = 0; lat[l] = 3; end
        ready_mode = 0; nl = 2; m_active = 1'b0; m_issue = 0; m_req_rr = 0; m_res_rr = 0;
        n_out = 0; n_done = 0; next_out = 0; max_span = 0; last_issue_cyc = -10;
        expect_dv = 0; dv2_events = 0; stale_acks = 0; check_order = 0; check_alt = 0;
        for (int a = 0; a < TOT; a++) begin outstanding[a] = 1'b0; seen[a] = 0; end
        repeat (2) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_frame_done", frame_done, 0);
        check_val("reset_data_valid", out_valid, 0);
        check_val("reset_data", {out_data, out_addr}, 0);
        check_val("reset_req_valid", req_valid, 0);
        check_val("reset_req_addr", req_addr, 0);
        step();
        rst = 1'b0;
        step();

        // Fixed latency, both lanes ready: strict order and alternating lanes.
        check_order = 1; check_alt = 1;
        run_frame("in_order", 200, -1);
        check_order = 0; check_alt = 0;

        // Slow lane 1 forces the window to fill.
        lat[0] = 1; lat[1] = 10; max_span = 0;
        run_frame("window_stall", 300, -1);
        check_val("window_span_reached", max_span, WIN);

        // Results of both lanes become valid in the same cycle.
        lat[0] = 4; lat[1] = 3; dv2_events = 0;
        run_frame("merge_collide", 300, -1);
        check_val("both_valid_seen", dv2_events > 0, 1);

        // A second frame_start in RUN is ignored.
        lat[0] = 2; lat[1] = 2;
        run_frame("restart_ignored", 300, 3);

        // Reset mid-frame with three pixels in flight, then a clean frame.
        lat[0] = 6; lat[1] = 6;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 20 && n_outstanding() != 3; i++) step();
        check_val("inflight_before_reset", n_outstanding(), 3);
        pending = q_cnt[0] + q_cnt[1];
        stale0  = stale_acks;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_val("post_reset_busy", busy, 0);
        check_val("post_reset_data_valid", out_valid, 0);
        for (int i = 0; i < 40 && (q_cnt[0] + q_cnt[1]) != 0; i++) step();
        check_val("stale_results_acked", stale_acks - stale0, pending);
        run_frame("after_reset", 300, -1);

        // Single-lane instance, lane ready every other cycle.
        sel1 = 1'b1; nl = 1; m_req_rr = 0; m_res_rr = 0;
        ready_mode = 1; lat[0] = 2;
        step();
        check_order = 1;
        run_frame("one_lane_half_rate", 400, -1);
        check_order = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
